// File: rtl/ram_width_adapter_32to16.sv
// Splits 32-bit NIC reads/writes into two 16-bit SRAM accesses (low half at even, high half at odd address).
// Optional read timeout with sticky error flag is enabled by defining SRAM_RD_TIMEOUT_EN.
module ram_width_adapter_32to16 #(
  parameter int RAM_ADDR_WIDTH  = 19,
  parameter int SRAM_ADDR_WIDTH = RAM_ADDR_WIDTH + 1,
  parameter int RD_TIMEOUT      = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [RAM_ADDR_WIDTH-1:0]  ram_address,
  input  logic [3:0]                 ram_byteenable_n,
  input  logic                       ram_chipselect,
  input  logic [31:0]                ram_writedata,
  input  logic                       ram_read_n,
  input  logic                       ram_write_n,
  output logic [31:0]                ram_readdata,
  output logic                       ram_readdatavalid,
  output logic                       ram_waitrequest,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_s_address,
  output logic [1:0]                 sram_s_byteenable,
  output logic                       sram_s_read,
  output logic                       sram_s_write,
  output logic [15:0]                sram_s_writedata,
  input  logic [15:0]                sram_s_readdata,
  input  logic                       sram_s_readdatavalid,
  input  logic                       sram_s_waitrequest,
  output logic                       rd_timeout_err
);

  typedef enum logic [2:0] {IDLE, LO, HI, RD_WAIT, DONE} state_e;

  state_e                    state_q, state_d;
  logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [3:0]                be_q, be_d;
  logic                      wr_q, wr_d;
  logic [15:0]               lo_q, lo_d;
  logic [15:0]               hi_q, hi_d;
  logic [1:0]                cnt_q, cnt_d;
  logic [31:0]               rdata_q, rdata_d;

  logic       accept;
  logic       lo_en;
  logic       hi_en;
  logic       rd_active;
  logic       ret;
  logic       timeout;
  logic [1:0] cnt_next;

  // Writes always win when both strobes are low together.
  assign accept    = (state_q == IDLE) && ram_chipselect && (!ram_read_n || !ram_write_n);
  assign lo_en     = !wr_q || (be_q[1:0] != 2'b00);
  assign hi_en     = !wr_q || (be_q[3:2] != 2'b00);
  assign rd_active = !wr_q && ((state_q == LO) || (state_q == HI) || (state_q == RD_WAIT));
  assign ret       = rd_active && sram_s_readdatavalid;
  assign cnt_next  = cnt_q + {1'b0, ret};

`ifdef SRAM_RD_TIMEOUT_EN
  localparam int TMO_W = $clog2(RD_TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  // A return arriving in the same cycle always beats the timeout.
  assign timeout = rd_active && !ret && (tmo_q == TMO_W'(RD_TIMEOUT - 1));

  always_comb begin
    tmo_d = tmo_q;
    if (accept || ret) begin
      tmo_d = '0;
    end else if (rd_active) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
    err_d = err_q | timeout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign rd_timeout_err = err_q;
`else
  assign timeout        = 1'b0;
  assign rd_timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = LO;
        end
      end
      LO: begin
        if (timeout) begin
          state_d = DONE;
        end else if (!lo_en) begin
          state_d = hi_en ? HI : IDLE;
        end else if (!sram_s_waitrequest) begin
          state_d = (wr_q && !hi_en) ? IDLE : HI;
        end
      end
      HI: begin
        if (timeout) begin
          state_d = DONE;
        end else if (!hi_en) begin
          state_d = IDLE;
        end else if (!sram_s_waitrequest) begin
          if (wr_q) begin
            state_d = IDLE;
          end else begin
            state_d = (cnt_next == 2'd2) ? DONE : RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (timeout || (cnt_next == 2'd2)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wr_d    = wr_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    if (accept) begin
      addr_d  = ram_address;
      wdata_d = ram_writedata;
      be_d    = ~ram_byteenable_n;
      wr_d    = !ram_write_n;
      lo_d    = 16'h0000;
      hi_d    = 16'h0000;
      cnt_d   = 2'd0;
    end else begin
      cnt_d = cnt_next;
      if (ret) begin
        if (cnt_q == 2'd0) begin
          lo_d = sram_s_readdata;
        end else begin
          hi_d = sram_s_readdata;
        end
      end
      // Halves that never came back are filled with a recognisable marker.
      if (timeout) begin
        if (cnt_q == 2'd0) begin
          lo_d = 16'hDEAD;
        end
        hi_d = 16'hDEAD;
      end
    end
    if ((state_d == DONE) && (state_q != DONE)) begin
      rdata_d = {hi_d, lo_d};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      wr_q    <= 1'b0;
      lo_q    <= 16'h0;
      hi_q    <= 16'h0;
      cnt_q   <= 2'd0;
      rdata_q <= 32'h0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    sram_s_address    = '0;
    sram_s_byteenable = 2'b00;
    sram_s_read       = 1'b0;
    sram_s_write      = 1'b0;
    sram_s_writedata  = 16'h0000;
    case (state_q)
      LO: begin
        if (lo_en) begin
          sram_s_address    = {addr_q, 1'b0};
          sram_s_byteenable = wr_q ? be_q[1:0] : 2'b11;
          sram_s_read       = !wr_q;
          sram_s_write      = wr_q;
          sram_s_writedata  = wr_q ? wdata_q[15:0] : 16'h0000;
        end
      end
      HI: begin
        if (hi_en) begin
          sram_s_address    = {addr_q, 1'b1};
          sram_s_byteenable = wr_q ? be_q[3:2] : 2'b11;
          sram_s_read       = !wr_q;
          sram_s_write      = wr_q;
          sram_s_writedata  = wr_q ? wdata_q[31:16] : 16'h0000;
        end
      end
      default: begin
      end
    endcase
  end

  assign ram_waitrequest   = (state_q != IDLE);
  assign ram_readdatavalid = (state_q == DONE);
  assign ram_readdata      = rdata_q;

endmodule

// File: tb/tb_ram_width_adapter_32to16.sv
// Scoreboard bench for ram_width_adapter_32to16: expected SRAM strobes and read words are queued
// when a request is driven and popped as the adapter produces them.
module tb_ram_width_adapter_32to16;

  localparam int AW = 19;
  localparam int SW = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] ram_address;
  logic [3:0]    ram_byteenable_n;
  logic          ram_chipselect;
  logic [31:0]   ram_writedata;
  logic          ram_read_n;
  logic          ram_write_n;
  logic [31:0]   ram_readdata;
  logic          ram_readdatavalid;
  logic          ram_waitrequest;
  logic [SW-1:0] sram_s_address;
  logic [1:0]    sram_s_byteenable;
  logic          sram_s_read;
  logic          sram_s_write;
  logic [15:0]   sram_s_writedata;
  logic [15:0]   sram_s_readdata;
  logic          sram_s_readdatavalid;
  logic          sram_s_waitrequest;
  logic          rd_timeout_err;

  always #5 clk = ~clk;

  ram_width_adapter_32to16 dut (
    .clk                  (clk),
    .reset                (reset),
    .ram_address          (ram_address),
    .ram_byteenable_n     (ram_byteenable_n),
    .ram_chipselect       (ram_chipselect),
    .ram_writedata        (ram_writedata),
    .ram_read_n           (ram_read_n),
    .ram_write_n          (ram_write_n),
    .ram_readdata         (ram_readdata),
    .ram_readdatavalid    (ram_readdatavalid),
    .ram_waitrequest      (ram_waitrequest),
    .sram_s_address       (sram_s_address),
    .sram_s_byteenable    (sram_s_byteenable),
    .sram_s_read          (sram_s_read),
    .sram_s_write         (sram_s_write),
    .sram_s_writedata     (sram_s_writedata),
    .sram_s_readdata      (sram_s_readdata),
    .sram_s_readdatavalid (sram_s_readdatavalid),
    .sram_s_waitrequest   (sram_s_waitrequest),
    .rd_timeout_err       (rd_timeout_err)
  );

  typedef struct packed {
    logic          wr;
    logic [SW-1:0] addr;
    logic [1:0]    be;
    logic [15:0]   data;
  } op_t;

  typedef struct packed {
    int          due;
    logic [15:0] data;
  } pend_t;

  op_t         exp_ops[$];
  logic [31:0] exp_rd[$];
  pend_t       pend[$];
  logic [15:0] mem[int];
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  int          rd_lat = 1;
  bit          suppress_hi = 1'b0;
  bit          prev_rdv = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request for a single accept edge and queues the SRAM strobes it should cause.
  task automatic applyStimulus(input logic rd_n, input logic wr_n, input logic [AW-1:0] addr,
                               input logic [31:0] data, input logic [3:0] be_n);
    op_t op;
    ram_chipselect   = 1'b1;
    ram_read_n       = rd_n;
    ram_write_n      = wr_n;
    ram_address      = addr;
    ram_writedata    = data;
    ram_byteenable_n = be_n;
    if (!wr_n) begin
      if (be_n[1:0] != 2'b11) begin
        op = '{wr: 1'b1, addr: {addr, 1'b0}, be: ~be_n[1:0], data: data[15:0]};
        exp_ops.push_back(op);
      end
      if (be_n[3:2] != 2'b11) begin
        op = '{wr: 1'b1, addr: {addr, 1'b1}, be: ~be_n[3:2], data: data[31:16]};
        exp_ops.push_back(op);
      end
    end else begin
      op = '{wr: 1'b0, addr: {addr, 1'b0}, be: 2'b11, data: 16'h0};
      exp_ops.push_back(op);
      op = '{wr: 1'b0, addr: {addr, 1'b1}, be: 2'b11, data: 16'h0};
      exp_ops.push_back(op);
    end
    tick();
    ram_chipselect = 1'b0;
    ram_read_n     = 1'b1;
    ram_write_n    = 1'b1;
  endtask

  task automatic waitIdle(output int n, input int limit);
    n = 0;
    while (ram_waitrequest && (n < limit)) begin
      n++;
      tick();
    end
    if (n >= limit) begin
      checkOutput("idle_bound", 64'(ram_waitrequest), 64'd0);
    end
  endtask

  // SRAM controller model: returns mem contents rd_lat cycles after a read strobe is taken.
  initial begin
    sram_s_readdatavalid = 1'b0;
    sram_s_readdata      = 16'h0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if ((pend.size() > 0) && (pend[0].due == cyc)) begin
        sram_s_readdatavalid = 1'b1;
        sram_s_readdata      = pend[0].data;
        pend.delete(0);
      end else begin
        sram_s_readdatavalid = 1'b0;
        sram_s_readdata      = 16'h0;
      end
    end
  end

  always @(negedge clk) begin : monitor
    op_t obs;
    op_t expo;
    if (!reset) begin
      if ((sram_s_read || sram_s_write) && !sram_s_waitrequest) begin
        obs.wr   = sram_s_write;
        obs.addr = sram_s_address;
        obs.be   = sram_s_byteenable;
        obs.data = sram_s_write ? sram_s_writedata : 16'h0;
        checkOutput("strobe_expected", 64'(exp_ops.size() > 0), 64'd1);
        if (exp_ops.size() > 0) begin
          expo = exp_ops.pop_front();
          checkOutput("sram_op", 64'(obs), 64'(expo));
        end
        if (sram_s_read && !(suppress_hi && sram_s_address[0])) begin
          pend.push_back('{due: cyc + rd_lat, data: mem[int'(sram_s_address)]});
        end
      end
      if (ram_readdatavalid) begin
        checkOutput("rdv_single_pulse", 64'(prev_rdv), 64'd0);
        checkOutput("rdv_expected", 64'(exp_rd.size() > 0), 64'd1);
        if (exp_rd.size() > 0) begin
          checkOutput("readdata", 64'(ram_readdata), 64'(exp_rd.pop_front()));
        end
      end
    end
    prev_rdv = ram_readdatavalid;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    reset              = 1'b1;
    ram_address        = '0;
    ram_byteenable_n   = 4'hF;
    ram_chipselect     = 1'b0;
    ram_writedata      = 32'h0;
    ram_read_n         = 1'b1;
    ram_write_n        = 1'b1;
    sram_s_waitrequest = 1'b0;
    #2;
    checkOutput("rst_waitrequest", 64'(ram_waitrequest), 64'd0);
    checkOutput("rst_rdv", 64'(ram_readdatavalid), 64'd0);
    checkOutput("rst_readdata", 64'(ram_readdata), 64'd0);
    checkOutput("rst_sram_rd", 64'(sram_s_read), 64'd0);
    checkOutput("rst_sram_wr", 64'(sram_s_write), 64'd0);
    checkOutput("rst_sram_addr", 64'(sram_s_address), 64'd0);
    checkOutput("rst_timeout_err", 64'(rd_timeout_err), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] full write");
    applyStimulus(1'b1, 1'b0, 19'h00012, 32'hA5A55A5A, 4'h0);
    waitIdle(n, 50);
    checkOutput("wr_full_wait_cycles", 64'(n), 64'd2);
    checkOutput("wr_full_ops_left", 64'(exp_ops.size()), 64'd0);

    $display("[TB] low-half-only write");
    applyStimulus(1'b1, 1'b0, 19'h00100, 32'h12345678, 4'hC);
    waitIdle(n, 50);
    checkOutput("wr_lo_ops_left", 64'(exp_ops.size()), 64'd0);

    $display("[TB] write with no byte enables");
    applyStimulus(1'b1, 1'b0, 19'h00200, 32'hDEADBEEF, 4'hF);
    waitIdle(n, 50);
    checkOutput("wr_none_wait_cycles", 64'(n), 64'd1);

    $display("[TB] both strobes low is a write");
    applyStimulus(1'b0, 1'b0, 19'h00300, 32'h0000FFFF, 4'h0);
    waitIdle(n, 50);
    checkOutput("wr_both_ops_left", 64'(exp_ops.size()), 64'd0);
    checkOutput("wr_both_no_rdv", 64'(exp_rd.size()), 64'd0);

    $display("[TB] read top address with LO stall");
    mem[32'hFFFFE] = 16'hBEEF;
    mem[32'hFFFFF] = 16'hCAFE;
    rd_lat = 3;
    exp_rd.push_back(32'hCAFEBEEF);
    applyStimulus(1'b0, 1'b1, 19'h7FFFF, 32'h0, 4'h0);
    sram_s_waitrequest = 1'b1;
    checkOutput("stall_addr_1", 64'(sram_s_address), 64'hFFFFE);
    checkOutput("stall_read_1", 64'(sram_s_read), 64'd1);
    tick();
    checkOutput("stall_addr_2", 64'(sram_s_address), 64'hFFFFE);
    tick();
    sram_s_waitrequest = 1'b0;
    waitIdle(n, 50);
    checkOutput("rd_top_rd_left", 64'(exp_rd.size()), 64'd0);
    checkOutput("rd_top_hold", 64'(ram_readdata), 64'hCAFEBEEF);
    tick();
    checkOutput("rd_top_hold_later", 64'(ram_readdata), 64'hCAFEBEEF);

    $display("[TB] low return coincides with HI strobe");
    mem[32'h00080] = 16'h1357;
    mem[32'h00081] = 16'h2468;
    rd_lat = 1;
    exp_rd.push_back(32'h24681357);
    applyStimulus(1'b0, 1'b1, 19'h00040, 32'h0, 4'h0);
    waitIdle(n, 50);
    checkOutput("rd_coinc_rd_left", 64'(exp_rd.size()), 64'd0);
    checkOutput("rd_coinc_ops_left", 64'(exp_ops.size()), 64'd0);

    $display("[TB] reset while waiting for the high return");
    mem[32'h00010] = 16'h7777;
    rd_lat = 2;
    suppress_hi = 1'b1;
    applyStimulus(1'b0, 1'b1, 19'h00008, 32'h0, 4'h0);
    repeat (8) tick();
    checkOutput("rd_stuck_wait", 64'(ram_waitrequest), 64'd1);
    checkOutput("rd_stuck_ops_left", 64'(exp_ops.size()), 64'd0);
    reset = 1'b1;
    #1;
    checkOutput("midrst_waitrequest", 64'(ram_waitrequest), 64'd0);
    checkOutput("midrst_rdv", 64'(ram_readdatavalid), 64'd0);
    checkOutput("midrst_readdata", 64'(ram_readdata), 64'd0);
    checkOutput("midrst_sram_rd", 64'(sram_s_read), 64'd0);
    checkOutput("midrst_sram_addr", 64'(sram_s_address), 64'd0);
    pend.delete();
    suppress_hi = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    mem[32'h00002] = 16'h0F0F;
    mem[32'h00003] = 16'hF00F;
    exp_rd.push_back(32'hF00F0F0F);
    applyStimulus(1'b0, 1'b1, 19'h00001, 32'h0, 4'h0);
    waitIdle(n, 50);
    checkOutput("rd_after_rst_left", 64'(exp_rd.size()), 64'd0);

`ifdef SRAM_RD_TIMEOUT_EN
    $display("[TB] read timeout with only the low return");
    mem[32'h00020] = 16'h1111;
    suppress_hi = 1'b1;
    exp_rd.push_back(32'hDEAD1111);
    applyStimulus(1'b0, 1'b1, 19'h00010, 32'h0, 4'h0);
    waitIdle(n, 200);
    checkOutput("tmo_rd_left", 64'(exp_rd.size()), 64'd0);
    checkOutput("tmo_err_set", 64'(rd_timeout_err), 64'd1);
    suppress_hi = 1'b0;
    exp_rd.push_back(32'hF00F0F0F);
    applyStimulus(1'b0, 1'b1, 19'h00001, 32'h0, 4'h0);
    waitIdle(n, 50);
    checkOutput("tmo_err_sticky", 64'(rd_timeout_err), 64'd1);
`else
    checkOutput("timeout_err_tied", 64'(rd_timeout_err), 64'd0);
`endif

    tick();
    checkOutput("final_ops_left", 64'(exp_ops.size()), 64'd0);
    checkOutput("final_rd_left", 64'(exp_rd.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ram_width_adapter_32to16.md
Name: ram_width_adapter_32to16

Overview:
- Sits between the external-RAM NIC's 32-bit memory-master interface and a single 16-bit SRAM controller slave port.
- Converts each 32-bit read or write into two sequenced 16-bit accesses: low half at even address, high half at odd address.
- Assembles read data and presents it back to the NIC with Avalon-style waitrequest/readdatavalid.
- Lets a NoC memory node use a single 16-bit SRAM chip instead of two.

Parameters:
- RAM_ADDR_WIDTH, 19, 32-bit word address width seen by the NIC.
- SRAM_ADDR_WIDTH, RAM_ADDR_WIDTH+1, 16-bit halfword address width at the SRAM controller.
- RD_TIMEOUT, 64, cycles without an SRAM readdatavalid before a read is force-completed (optional feature only).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- ram_address  in  RAM_ADDR_WIDTH  word address from NIC
- ram_byteenable_n  in  4  active-low byte enables
- ram_chipselect  in  1  request qualifier
- ram_writedata  in  32  write data
- ram_read_n  in  1  active-low read strobe
- ram_write_n  in  1  active-low write strobe
- ram_readdata  out  32  assembled read data
- ram_readdatavalid  out  1  one-cycle read completion pulse
- ram_waitrequest  out  1  adapter busy; NIC holds its request
- sram_s_address  out  SRAM_ADDR_WIDTH  halfword address
- sram_s_byteenable  out  2  active-high byte enables
- sram_s_read  out  1  read strobe
- sram_s_write  out  1  write strobe
- sram_s_writedata  out  16  halfword write data
- sram_s_readdata  in  16  halfword read data
- sram_s_readdatavalid  in  1  halfword read return, in order
- sram_s_waitrequest  in  1  controller stall
- rd_timeout_err  out  1  sticky read-timeout flag

Behaviour:
- Reset: state IDLE; all registered outputs are 0; ram_waitrequest is 0.
- ram_waitrequest = (state != IDLE), combinational.
- Accept: in IDLE when ram_chipselect=1 and either strobe is low. Latch address, data, byte enables and type.
- If both strobes are low at the same time, the request is a write and the read is ignored.
- States:
  - IDLE
  - LO: issue low half
  - HI: issue high half
  - RD_WAIT: collect returns
  - DONE: pulse readdatavalid
- SRAM address mapping: LO uses {addr,1'b0}; HI uses {addr,1'b1}.
- Write data and byte enables:
  - LO: data [15:0], byte enables ~be_n[1:0].
  - HI: data [31:16], byte enables ~be_n[3:2].
- Strobe hold: the SRAM strobe is held with stable address and data until a cycle with sram_s_waitrequest=0. The state advances on that cycle.
- Write half-skip: a half whose two byte enables are both inactive is skipped (no SRAM strobe).
- Write with all byte enables inactive: IDLE → accept → IDLE with no SRAM access; waitrequest is high for 1 cycle.
- Reads always access both halves with byteenable=2'b11.
- Write path: LO → HI → IDLE.
- Read path: LO → HI → RD_WAIT.
- Return counting: a 2-bit counter counts sram_s_readdatavalid from the first read issue. Returns may arrive in LO, HI or RD_WAIT, including in the same cycle a strobe is accepted.
  - First return is latched as the low half; second return as the high half.
  - When the count reaches 2 → DONE.
- DONE: ram_readdatavalid=1 for exactly one cycle with ram_readdata={hi,lo}, then IDLE. ram_readdata holds its value until the next read completes.
- Minimum latency, zero SRAM stalls:
  - Write accepted at cycle T: LO at T+1, HI at T+2, waitrequest low at T+3.
  - Read: readdatavalid one cycle after the second SRAM return.
- sram_s_readdatavalid in IDLE is ignored.
- At most one upstream transaction is outstanding.
- Reset mid-operation: returns to IDLE and clears the counter and latched data. The SRAM controller shares the reset, so no stale returns arrive.

Optional Feature:
- Macro: SRAM_RD_TIMEOUT_EN.
- Defined:
  - A counter runs while a read is in LO, HI or RD_WAIT. It clears on each sram_s_readdatavalid and on accept.
  - When it reaches RD_TIMEOUT: missing halves are filled with 16'hDEAD, DONE proceeds normally, and rd_timeout_err sets.
  - rd_timeout_err is sticky and cleared only by reset.
- Undefined: no counter; a read waits indefinitely; rd_timeout_err is tied 0.

Test Plan:
- Write addr=0x00012, data=0xA5A55A5A, be_n=0x0, no stalls → SRAM writes 0x5A5A@0x00024 then 0xA5A5@0x00025 on consecutive cycles; waitrequest high exactly 2 cycles.
- Write be_n=0xC, data=0x12345678 → only a low-half write of 0x5678, byteenable 2'b11; no HI strobe. Write be_n=0xF → no SRAM strobe at all.
- Read addr=0x7FFFF with SRAM returns 0xBEEF then 0xCAFE after 3-cycle latency, and sram_s_waitrequest high 2 cycles on the LO issue → address 0xFFFFE then 0xFFFFF; one readdatavalid pulse with 0xCAFEBEEF.
- Read where the low-half return coincides with the HI strobe acceptance → correct assembly; no dropped return.
- Assert reset during RD_WAIT after one return → all outputs 0, IDLE; a following read of 0x00001 returns correct data.
- With SRAM_RD_TIMEOUT_EN, RD_TIMEOUT=64, and only the low return (0x1111) given → readdatavalid 64 cycles after the last return with 0xDEAD1111; rd_timeout_err=1 and stays set.
